mdu_issue_ctrl: RTL and testbench

//   Issue/hazard controller for the E-stage multiply/divide unit (MDU). Decides when an
//   E-stage mult/multu/div/divu may start, mirrors the MDU's latency with its own countdown,
//   and stalls the D stage while an instruction touching the MDU or HI/LO must wait.

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_issue_ctrl.sv | 96 +++++++++
 tb/tb_mdu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU op encoding, FSM state type and op classification helpers.
// Imported by the MDU and its issue controller so both agree on op codes.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] OP_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] OP_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] OP_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_start(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Codes above MTLO are unknown and behave exactly like OP_NONE.
  function automatic logic is_mdu_op(input logic [MDU_OP_W-1:0] op);
    return (op != OP_NONE) && (op <= OP_MTLO);
  endfunction

  function automatic int latency(input logic [MDU_OP_W-1:0] op,
                                 input int mul_cycles,
                                 input int div_cycles);
    return is_div(op) ? div_cycles : mul_cycles;
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// Issue/hazard control for the E-stage MDU; start is same-cycle, busy spans start..start+N.
// No backpressure input: stall_d holds D while busy. Optional counters under MDU_CTRL_STATS_EN.
// proto_err is sticky on an illegal issue during RUN or an MDU busy mismatch.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_mdu_use,
  input  logic                e_valid,
  input  logic [MDU_OP_W-1:0] e_op,
  input  logic                mdu_busy,
  output logic [MDU_OP_W-1:0] mdu_op,
  output logic                mdu_start,
  output logic                busy,
  output logic                stall_d,
`ifdef MDU_CTRL_STATS_EN
  output logic [31:0]         stat_ops,
  output logic [31:0]         stat_stall,
`endif
  output logic                proto_err
);

  mdu_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_d;
  logic                   op_vld;

  assign op_vld = e_valid && is_mdu_op(e_op);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = proto_err;
    mdu_op    = OP_NONE;
    mdu_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_vld) begin
          mdu_op = e_op;
          if (is_start(e_op)) begin
            mdu_start = 1'b1;
            state_d   = RUN;
            cnt_d     = CNT_W'(latency(e_op, MUL_CYCLES, DIV_CYCLES));
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
        // Anything reaching E now was not held off by stall_d: the pipeline broke protocol.
        if (op_vld || !mdu_busy) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy    = mdu_start || (state_q == RUN);
  assign stall_d = d_mdu_use && busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      proto_err <= err_d;
    end
  end

`ifdef MDU_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (mdu_start) stat_ops <= stat_ops + 32'd1;
      if (stall_d)   stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed scenarios plus random traffic against a cycle-count model.
// The model tracks the cycle at which the MDU becomes free rather than any FSM state.
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d_mdu_use = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic        mdu_busy;
  logic [3:0]  mdu_op;
  logic        mdu_start, busy, stall_d, proto_err;
`ifdef MDU_CTRL_STATS_EN
  logic [31:0] stat_ops, stat_stall;
`endif

  always #5 clk = ~clk;

  // Model: the MDU is occupied while cyc_n < free_at.
  int          cyc_n = 0;
  int          free_at = 0;
  bit          m_err = 1'b0;
  bit          drop_busy = 1'b0;
  logic [31:0] m_ops = 0, m_stall = 0;

  int          n_chk = 0, n_pass = 0;
  logic [75:0] obs, expv;
  logic [3:0]  o_op, o_cnt;
  logic        o_start, o_busy, o_stall, o_err;

  assign mdu_busy = (cyc_n < free_at) && !drop_busy;

  mdu_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_mdu_use (d_mdu_use),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .mdu_busy  (mdu_busy),
    .mdu_op    (mdu_op),
    .mdu_start (mdu_start),
    .busy      (busy),
    .stall_d   (stall_d),
`ifdef MDU_CTRL_STATS_EN
    .stat_ops  (stat_ops),
    .stat_stall(stat_stall),
`endif
    .proto_err (proto_err)
  );

  task automatic drive(input bit v, input logic [3:0] op, input bit d);
    e_valid   = v;
    e_op      = op;
    d_mdu_use = d;
  endtask

  // One clock: compute expectations and sample outputs mid-cycle, then advance the model.
  task automatic cyc();
    bit run, vop, st, stl, bsy;
    logic [3:0] eop;
    int ecnt;
    logic [63:0] st_e, st_o;
    @(negedge clk);
    run  = cyc_n < free_at;
    vop  = e_valid && (e_op >= 4'd1) && (e_op <= 4'd8);
    st   = !run && vop && (e_op <= 4'd4);
    eop  = (!run && vop) ? e_op : 4'd0;
    stl  = d_mdu_use && (st || run);
    ecnt = run ? (free_at - cyc_n) : 0;
    bsy  = mdu_busy;
`ifdef MDU_CTRL_STATS_EN
    st_e = {m_ops, m_stall};
    st_o = {stat_ops, stat_stall};
`else
    st_e = 64'd0;
    st_o = 64'd0;
`endif
    expv = {eop, st, st || run, stl, m_err, 4'(ecnt), st_e};
    o_op = mdu_op; o_start = mdu_start; o_busy = busy; o_stall = stall_d;
    o_err = proto_err; o_cnt = dut.cnt_q;
    obs  = {o_op, o_start, o_busy, o_stall, o_err, o_cnt, st_o};
    @(posedge clk);
    #1;
    if (reset) begin
      free_at = 0;
      m_err   = 1'b0;
      m_ops   = 0;
      m_stall = 0;
    end else begin
      if (run && (vop || !bsy)) m_err = 1'b1;
      if (st) begin
        free_at = cyc_n + 1 + ((e_op >= 4'd3) ? 10 : 5);
        m_ops   = m_ops + 1;
      end
      if (stl) m_stall = m_stall + 1;
    end
    cyc_n++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, OP_NONE, 0);
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if ({o_busy, o_stall, o_op, o_err, o_start} !== 8'd0)
        $display("FAIL reset_idle cyc=%0d got busy=%0b stall=%0b op=%0d err=%0b start=%0b required all 0",
                 i, o_busy, o_stall, o_op, o_err, o_start);
      else n_pass++;
    end
  endtask

  task automatic test_mult();
    int starts = 0, stalls = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1, OP_MULT, 1); else drive(0, OP_NONE, 1);
      cyc();
      starts += int'(o_start);
      stalls += int'(o_stall);
      n_chk++;
      if (obs !== expv) $display("FAIL mult_model cyc=%0d got=%h required=%h", i, obs, expv);
      else n_pass++;
    end
    n_chk++;
    if (starts !== 1) $display("FAIL mult_start_count got=%0d required=1", starts); else n_pass++;
    n_chk++;
    if (stalls !== 6) $display("FAIL mult_stall_count got=%0d required=6", stalls); else n_pass++;
  endtask

  task automatic test_divu_mflo();
    int stalls = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) drive(1, OP_DIVU, 1);
      else if (i == 11) drive(1, OP_MFLO, 0);
      else drive(0, OP_NONE, 1);
      cyc();
      stalls += int'(o_stall);
      n_chk++;
      if (obs !== expv) $display("FAIL divu_model cyc=%0d got=%h required=%h", i, obs, expv);
      else n_pass++;
    end
    n_chk++;
    if (stalls !== 11) $display("FAIL divu_stall_count got=%0d required=11", stalls); else n_pass++;
    n_chk++;
    if ({o_op, o_start} !== {4'd6, 1'b0})
      $display("FAIL mflo_issue got op=%0d start=%0b required op=6 start=0", o_op, o_start);
    else n_pass++;
    drive(0, OP_NONE, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 18; i++) begin
      if (i == 0) drive(1, OP_MULT, 0);
      else if (i == 6) drive(1, OP_DIV, 0);
      else drive(0, OP_NONE, 0);
      cyc();
      n_chk++;
      if (obs !== expv) $display("FAIL b2b_model cyc=%0d got=%h required=%h", i, obs, expv);
      else n_pass++;
      if (i == 6) begin
        n_chk++;
        if (o_start !== 1'b1) $display("FAIL b2b_div_start got=%0b required=1", o_start); else n_pass++;
      end
      if (i == 7) begin
        n_chk++;
        if (o_cnt !== 4'd10) $display("FAIL b2b_div_cnt got=%0d required=10", o_cnt); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 11; i++) begin
      reset = (i == 3);
      if (i == 0) drive(1, OP_DIV, 0);
      else if (i == 5) drive(1, OP_MULT, 0);
      else drive(0, OP_NONE, 0);
      cyc();
      n_chk++;
      if (obs !== expv) $display("FAIL rst_mid_model cyc=%0d got=%h required=%h", i, obs, expv);
      else n_pass++;
      if (i == 4) begin
        n_chk++;
        if ({o_busy, o_cnt} !== 5'd0)
          $display("FAIL rst_mid_abort got busy=%0b cnt=%0d required busy=0 cnt=0", o_busy, o_cnt);
        else n_pass++;
      end
      if (i == 5) begin
        n_chk++;
        if (o_start !== 1'b1) $display("FAIL rst_mid_new_mult got=%0b required=1", o_start); else n_pass++;
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_proto_err();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1, OP_MULT, 0);
      else if (i == 2) drive(1, OP_MTHI, 0);
      else drive(0, OP_NONE, 0);
      cyc();
      n_chk++;
      if (obs !== expv) $display("FAIL illegal_issue_model cyc=%0d got=%h required=%h", i, obs, expv);
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if (o_op !== 4'd0) $display("FAIL illegal_issue_op got=%0d required=0", o_op); else n_pass++;
      end
    end
    n_chk++;
    if (o_err !== 1'b1) $display("FAIL illegal_issue_sticky got=%0b required=1", o_err); else n_pass++;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drop_busy = (i == 2);
      if (i == 0) drive(1, OP_MULT, 0); else drive(0, OP_NONE, 0);
      cyc();
      n_chk++;
      if (obs !== expv) $display("FAIL busy_mismatch_model cyc=%0d got=%h required=%h", i, obs, expv);
      else n_pass++;
    end
    drop_busy = 1'b0;
    n_chk++;
    if (o_err !== 1'b1) $display("FAIL busy_mismatch_err got=%0b required=1", o_err); else n_pass++;
  endtask

  task automatic test_random();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      drop_busy = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      cyc();
      n_chk++;
      if (obs !== expv) $display("FAIL random_model cyc=%0d got=%h required=%h", i, obs, expv);
      else n_pass++;
    end
    reset     = 1'b0;
    drop_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_mflo();
    test_back_to_back();
    test_reset_mid_run();
    test_proto_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
